// File: rtl/conv_pkg.sv
// Shared types, widths and fixed 3x3 kernels for the conv_3x3 filter stage.
package conv_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned ACC_W  = 21;
  localparam int unsigned HC_W   = 11;
  localparam int unsigned VC_W   = 10;

  typedef logic signed [COEF_W-1:0] coef_t;
  // kernel[row][col], row 0 = top, col 0 = left
  typedef coef_t [0:2][0:2] kernel_t;

  // Sideband that travels alongside the arithmetic pipeline
  typedef struct packed {
    logic            valid;
    logic            border;
    logic [HC_W-1:0] h;
    logic [VC_W-1:0] v;
  } side_t;

  localparam kernel_t GAUSS_KERNEL = '{
    '{ 8'sd1,  8'sd2,  8'sd1},
    '{ 8'sd2,  8'sd4,  8'sd2},
    '{ 8'sd1,  8'sd2,  8'sd1}
  };

  localparam kernel_t SOBEL_X_KERNEL = '{
    '{-8'sd1,  8'sd0,  8'sd1},
    '{-8'sd2,  8'sd0,  8'sd2},
    '{-8'sd1,  8'sd0,  8'sd1}
  };

  localparam kernel_t SOBEL_Y_KERNEL = '{
    '{-8'sd1, -8'sd2, -8'sd1},
    '{ 8'sd0,  8'sd0,  8'sd0},
    '{ 8'sd1,  8'sd2,  8'sd1}
  };

  function automatic kernel_t kernel_sel(input int unsigned id);
    case (id)
      32'd1:   kernel_sel = SOBEL_X_KERNEL;
      32'd2:   kernel_sel = SOBEL_Y_KERNEL;
      default: kernel_sel = GAUSS_KERNEL;
    endcase
  endfunction

endpackage

// File: rtl/conv_window.sv
// S1: 3-column sliding window, centre-coordinate/row-wrap tracking and border flag.
module conv_window
  import conv_pkg::*;
#(
  parameter int unsigned HRES = 640,
  parameter int unsigned VRES = 360
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [2:0][PIX_W-1:0]       col_i,
  input  logic [HC_W-1:0]             hcount_i,
  input  logic [VC_W-1:0]             vcount_i,
  input  logic                        valid_i,
  output logic [2:0][2:0][PIX_W-1:0]  win_o,
  output logic [HC_W-1:0]             h_o,
  output logic [VC_W-1:0]             v_o,
  output logic                        border_o,
  output logic                        valid_o
);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(HRES - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(VRES - 1);

  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [HC_W-1:0]            h_q, h_d;
  logic [VC_W-1:0]            v_q, v_d;
  logic [VC_W-1:0]            last_v_q, last_v_d;
  logic                       border_q, border_d;
  logic                       valid_q;

  // Window shifts only on valid columns; centre is the previous column
  always_comb begin
    win_d    = win_q;
    h_d      = h_q;
    v_d      = v_q;
    last_v_d = last_v_q;
    border_d = border_q;
    if (valid_i) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = col_i;
      last_v_d = vcount_i;
      if (hcount_i != '0) begin
        h_d = hcount_i - HC_W'(1);
        v_d = vcount_i;
      end else begin
        h_d = H_LAST;
        v_d = last_v_q;
      end
      border_d = (h_d == '0) || (h_d == H_LAST) || (v_d == '0) || (v_d == V_LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      last_v_q <= '0;
      border_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      win_q    <= win_d;
      h_q      <= h_d;
      v_q      <= v_d;
      last_v_q <= last_v_d;
      border_q <= border_d;
      valid_q  <= valid_i;
    end
  end

  assign win_o    = win_q;
  assign h_o      = h_q;
  assign v_o      = v_q;
  assign border_o = border_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/conv_3x3.sv
// Fixed-kernel 3x3 convolution: window (S1), products (S2), sum (S3), shift/abs/clamp (S4).
module conv_3x3
  import conv_pkg::*;
#(
  parameter int unsigned HRES      = 640,
  parameter int unsigned VRES      = 360,
  parameter int unsigned KERNEL_ID = 0,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned ABS_EN    = 0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [2:0][7:0] line_buffer_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            data_valid_in,
  output logic [7:0]      pixel_out,
  output logic [10:0]     hcount_out,
  output logic [9:0]      vcount_out,
  output logic            data_valid_out
);

  localparam kernel_t KERN    = kernel_sel(KERNEL_ID);
  localparam bit      USE_ABS = (ABS_EN != 0);

  logic [2:0][2:0][PIX_W-1:0] s1_win;
  logic [HC_W-1:0]            s1_h;
  logic [VC_W-1:0]            s1_v;
  logic                       s1_border, s1_valid;
  side_t                      s1_side, s2_q, s3_q, s4_q;

  logic signed [PROD_W-1:0]   prod_d [3][3];
  logic signed [PROD_W-1:0]   prod_q [3][3];
  logic signed [ACC_W-1:0]    acc_d, acc_q;
  logic signed [ACC_W-1:0]    shifted, mag;
  logic [PIX_W-1:0]           pix_d, pix_q;

  conv_window #(
    .HRES (HRES),
    .VRES (VRES)
  ) u_window (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .col_i    (line_buffer_in),
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .valid_i  (data_valid_in),
    .win_o    (s1_win),
    .h_o      (s1_h),
    .v_o      (s1_v),
    .border_o (s1_border),
    .valid_o  (s1_valid)
  );

  assign s1_side = '{valid: s1_valid, border: s1_border, h: s1_h, v: s1_v};

  // Pixel is treated as a non-negative 9-bit signed operand
  function automatic logic signed [PROD_W-1:0] mul_tap(input logic [PIX_W-1:0] pix,
                                                       input coef_t coef);
    logic signed [PROD_W-1:0] a, b;
    a = PROD_W'($signed({1'b0, pix}));
    b = PROD_W'(coef);
    return a * b;
  endfunction

  // S2: window column c supplies kernel column c
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod_d[r][c] = mul_tap(s1_win[c][r], KERN[r][c]);
      end
    end
  end

  // S3
  always_comb begin
    acc_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc_d = acc_d + ACC_W'(prod_q[r][c]);
      end
    end
  end

  // S4: shift, optional magnitude, clamp, border blanking
  always_comb begin
    shifted = acc_q >>> SHIFT;
    mag     = shifted;
    if (USE_ABS && shifted[ACC_W-1]) begin
      mag = -shifted;
    end
    pix_d = '0;
    if (s3_q.border || mag[ACC_W-1]) begin
      pix_d = '0;
    end else if (mag > ACC_W'(255)) begin
      pix_d = '1;
    end else begin
      pix_d = mag[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod_q[r][c] <= '0;
        end
      end
      acc_q <= '0;
      pix_q <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s4_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      pix_q  <= pix_d;
      s2_q   <= s1_side;
      s3_q   <= s2_q;
      s4_q   <= s3_q;
    end
  end

  assign pixel_out      = pix_q;
  assign hcount_out     = s4_q.h;
  assign vcount_out     = s4_q.v;
  assign data_valid_out = s4_q.valid;

endmodule

// File: tb/tb_conv_3x3.sv
// Bench for conv_3x3: four kernel/shift/abs configurations driven by one shared column stream.
module tb_conv_3x3;

  localparam int HRES = 16;
  localparam int VRES = 8;
  localparam int ND   = 4;
  localparam int unsigned KID [ND] = '{0, 1, 1, 2};
  localparam int unsigned SH  [ND] = '{4, 0, 0, 0};
  localparam int unsigned AB  [ND] = '{0, 1, 0, 1};

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0][7:0] lb;
  logic [10:0]     hc;
  logic [9:0]      vc;
  logic            dv;

  logic [7:0]  pix  [ND];
  logic [10:0] hout [ND];
  logic [9:0]  vout [ND];
  logic        dvo  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    conv_3x3 #(
      .HRES      (HRES),
      .VRES      (VRES),
      .KERNEL_ID (KID[g]),
      .SHIFT     (SH[g]),
      .ABS_EN    (AB[g])
    ) u_dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .line_buffer_in (lb),
      .hcount_in      (hc),
      .vcount_in      (vc),
      .data_valid_in  (dv),
      .pixel_out      (pix[g]),
      .hcount_out     (hout[g]),
      .vcount_out     (vout[g]),
      .data_valid_out (dvo[g])
    );
  end

  typedef struct {
    int h;
    int v;
    int p [ND];
  } exp_t;

  typedef struct {
    int hc; int vc; int pix; int eh; int ev;
    int e0; int e1; int e2; int e3;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   prev_v = 0;
  bit   sb_en = 1'b0;
  exp_t q [$];
  exp_t e;
  logic [7:0] img [VRES+2][HRES];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Kernels expressed as separable row/column weights
  function automatic int coef(input int kid, input int r, input int c);
    case (kid)
      1:       return (c - 1) * ((r == 1) ? 2 : 1);
      2:       return (r - 1) * ((c == 1) ? 2 : 1);
      default: return ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
    endcase
  endfunction

  // Image rows v-1..v+1 live at img[v..v+2]
  function automatic int ref_pix(input int g, input int h, input int v);
    int s;
    if (h == 0 || h == HRES-1 || v == 0 || v == VRES-1) return 0;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += coef(int'(KID[g]), r, c) * int'(img[v+r][h-1+c]);
    s = s >>> SH[g];
    if (AB[g] != 0 && s < 0) s = -s;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dv = 1'b0;
    step();
  endtask

  task automatic send(input int x, input int v);
    exp_t n;
    lb = {img[v+2][x], img[v+1][x], img[v][x]};
    hc = 11'(x);
    vc = 10'(v);
    dv = 1'b1;
    n.h = (x == 0) ? HRES-1 : x-1;
    n.v = (x == 0) ? prev_v : v;
    for (int g = 0; g < ND; g++) n.p[g] = ref_pix(g, n.h, n.v);
    prev_v = v;
    q.push_back(n);
    step();
  endtask

  task automatic do_reset();
    dv  = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    prev_v = 0;
    q.delete();
  endtask

  task automatic fill(input int mode, input int val);
    for (int r = 0; r < VRES+2; r++)
      for (int c = 0; c < HRES; c++)
        case (mode)
          0: img[r][c] = 8'(val);
          1: img[r][c] = (c < HRES/2) ? 8'd0 : 8'd100;
          2: img[r][c] = (c < HRES/2) ? 8'd100 : 8'd0;
          default: img[r][c] = 8'($urandom_range(255));
        endcase
  endtask

  task automatic feed_frame(input int gap_pct);
    int o0;
    o0 = n_out;
    for (int v = 0; v < VRES; v++)
      for (int x = 0; x < HRES; x++) begin
        if (int'($urandom_range(99)) < gap_pct) repeat ($urandom_range(1, 2)) idle();
        send(x, v);
      end
    repeat (6) idle();
    chk("queue_drained", q.size(), 0);
    chk("frame_output_count", n_out - o0, HRES*VRES);
  endtask

  // Scoreboard: every output popped in order against the model
  always @(negedge clk) begin
    if (!rst && sb_en && dvo[0]) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        n_out++;
        for (int g = 0; g < ND; g++) begin
          chk($sformatf("sb_valid[%0d]", g), int'(dvo[g]), 1);
          chk($sformatf("sb_h[%0d]", g), int'(hout[g]), e.h);
          chk($sformatf("sb_v[%0d]", g), int'(vout[g]), e.v);
          chk($sformatf("sb_pix[%0d] h%0d v%0d", g, e.h, e.v), int'(pix[g]), e.p[g]);
        end
      end
    end
  end

  vec_t vt [6];

  initial begin
    int ep [ND];
    rst = 1'b1;
    dv  = 1'b0;
    lb  = '0;
    hc  = '0;
    vc  = '0;
    vt[0] = '{5,        3, 100,      4,    3, 25, 255, 255, 0};
    vt[1] = '{0,        8,  50, HRES-1,    0,  0,   0,   0, 0};
    vt[2] = '{1,        4, 200,      0,    4,  0,   0,   0, 0};
    vt[3] = '{HRES-1,   6,  16, HRES-2,    6,  4,  64,  64, 0};
    vt[4] = '{3,        7,  90,      2,    7,  0,   0,   0, 0};
    vt[5] = '{10,       2, 255,      9,    2, 63, 255, 255, 0};

    repeat (2) step();
    for (int g = 0; g < ND; g++) begin
      chk("reset_valid", int'(dvo[g]), 0);
      chk("reset_pix", int'(pix[g]), 0);
      chk("reset_h", int'(hout[g]), 0);
      chk("reset_v", int'(vout[g]), 0);
    end
    rst = 1'b0;

    // Single valid column after reset: one output, exactly 4 edges later
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ep = '{vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3};
      lb = {8'(vt[i].pix), 8'(vt[i].pix), 8'(vt[i].pix)};
      hc = 11'(vt[i].hc);
      vc = 10'(vt[i].vc);
      dv = 1'b1;
      step();
      dv = 1'b0;
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("vec%0d_valid_at_%0d", i, k), int'(dvo[0]), (k == 3) ? 1 : 0);
        if (k == 3) begin
          for (int g = 0; g < ND; g++) begin
            chk($sformatf("vec%0d_h[%0d]", i, g), int'(hout[g]), vt[i].eh);
            chk($sformatf("vec%0d_v[%0d]", i, g), int'(vout[g]), vt[i].ev);
            chk($sformatf("vec%0d_pix[%0d]", i, g), int'(pix[g]), ep[g]);
          end
        end
        step();
      end
    end

    // Row wrap: row 7 then (0,8) reports (HRES-1, 7)
    do_reset();
    fill(3, 0);
    for (int x = 0; x < HRES; x++) send(x, 7);
    lb = '0;
    hc = '0;
    vc = 10'd8;
    dv = 1'b1;
    step();
    dv = 1'b0;
    repeat (3) step();
    chk("wrap_valid", int'(dvo[0]), 1);
    chk("wrap_h", int'(hout[0]), HRES-1);
    chk("wrap_v", int'(vout[0]), 7);
    chk("wrap_pix", int'(pix[0]), 0);
    step();
    chk("wrap_single", int'(dvo[0]), 0);

    // Full frames through the scoreboard
    do_reset();
    sb_en = 1'b1;
    fill(0, 100);
    feed_frame(0);
    fill(1, 0);
    feed_frame(0);
    fill(2, 0);
    feed_frame(0);
    fill(3, 0);
    feed_frame(50);
    fill(3, 0);
    feed_frame(50);

    // Mid-row asynchronous reset
    fill(0, 100);
    for (int x = 0; x < 11; x++) send(x, 3);
    chk("pre_reset_valid", int'(dvo[0]), 1);
    chk("pre_reset_pix", int'(pix[0]), 100);
    #2;
    rst = 1'b1;
    dv  = 1'b0;
    q.delete();
    #1;
    for (int g = 0; g < ND; g++) begin
      chk("async_rst_valid", int'(dvo[g]), 0);
      chk("async_rst_pix", int'(pix[g]), 0);
      chk("async_rst_h", int'(hout[g]), 0);
      chk("async_rst_v", int'(vout[g]), 0);
    end
    repeat (2) step();
    #3;
    rst = 1'b0;
    prev_v = 0;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("post_reset_quiet", int'(dvo[0]), 0);
      step();
    end
    fill(3, 0);
    feed_frame(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
